// File: rtl/sipo_deframer_if.sv
// Serial-in / parallel-out deframer bus: serial line in, word handshake out.
interface sipo_deframer_if #(
   parameter int unsigned WIDTH = 4
);
   logic             serial_in;
   logic [WIDTH-1:0] parallel_out;
   logic             out_valid;
   logic             out_ready;
   logic             parity_err;
   logic             overrun;
   logic             busy;

   // Deframer side: consumes the serial line and presents words.
   modport slave (
      input  serial_in,
      input  out_ready,
      output parallel_out,
      output out_valid,
      output parity_err,
      output overrun,
      output busy
   );

   // Line driver / word consumer side.
   modport master (
      output serial_in,
      output out_ready,
      input  parallel_out,
      input  out_valid,
      input  parity_err,
      input  overrun,
      input  busy
   );
endinterface

// File: rtl/sipo_deframer.sv
// Deframes start-bit + LSB-first payload (+ optional even parity) into words
// with a one-deep valid/ready output holding register and sticky overrun flag.
module sipo_deframer #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned PARITY_EN = 1
) (
   input  logic           clk,
   input  logic           rst,
   sipo_deframer_if.slave bus
);
   localparam int unsigned CNT_W      = $clog2(WIDTH);
   localparam bit          HAS_PARITY = (PARITY_EN != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [WIDTH-1:0]   shift_q;
   logic [WIDTH-1:0]   shift_d;
   logic [WIDTH-1:0]   parallel_q;
   logic               valid_q;
   logic               perr_q;
   logic               ovr_q;

   logic               last_bit_c;
   logic               frame_done_c;
   logic [WIDTH-1:0]   payload_c;
   logic               mismatch_c;

   // Shift/count next values and frame-completion decode for the current edge.
   always_comb begin
      shift_d      = {bus.serial_in, shift_q[WIDTH-1:1]};
      cnt_d        = cnt_q + CNT_W'(1);
      last_bit_c   = (cnt_q == CNT_W'(WIDTH - 1));
      frame_done_c = 1'b0;
      payload_c    = shift_q;
      mismatch_c   = 1'b0;
      if (HAS_PARITY) begin
         if (state_q == PARITY) begin
            frame_done_c = 1'b1;
            mismatch_c   = (^shift_q) ^ bus.serial_in;
         end
      end else if ((state_q == DATA) && last_bit_c) begin
         // Without parity the last payload bit completes the frame on this edge.
         frame_done_c = 1'b1;
         payload_c    = shift_d;
      end
   end

   // Frame FSM plus output holding register; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         parallel_q <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.serial_in) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
               end
            end
            DATA: begin
               shift_q <= shift_d;
               cnt_q   <= cnt_d;
               if (last_bit_c) begin
                  state_q <= HAS_PARITY ? PARITY : IDLE;
               end
            end
            PARITY: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         // A completed frame lands only if the held word is empty or leaving now.
         if (frame_done_c) begin
            if (!valid_q || bus.out_ready) begin
               parallel_q <= payload_c;
               perr_q     <= mismatch_c;
               valid_q    <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.parallel_out = parallel_q;
   assign bus.out_valid    = valid_q;
   assign bus.parity_err   = perr_q;
   assign bus.overrun      = ovr_q;
   assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_deframer.sv
// Randomized + directed bench for sipo_deframer with a frame-level reference
// model feeding an expected-word queue that a negedge monitor drains.
module tb_sipo_deframer;
   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sipo_deframer_if #(.WIDTH(W)) bus0 ();
   sipo_deframer_if #(.WIDTH(W)) bus1 ();

   sipo_deframer #(.WIDTH(W), .PARITY_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   sipo_deframer #(.WIDTH(W), .PARITY_EN(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   typedef struct packed {
      logic [W-1:0] data;
      logic         err;
   } exp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;
   exp_t exp_q[$];

   // Reference model state for dut0 (parity enabled), frame-level view.
   bit           m_valid   = 1'b0;
   bit           m_ovr     = 1'b0;
   bit           m_inframe = 1'b0;
   int           m_idx     = 0;
   logic [W-1:0] m_pay     = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge given the inputs seen at that edge.
   task automatic model_edge(input bit rs, input bit s, input bit r);
      bit done;
      bit err;
      done = 1'b0;
      err  = 1'b0;
      if (rs) begin
         m_valid   = 1'b0;
         m_ovr     = 1'b0;
         m_inframe = 1'b0;
         m_idx     = 0;
         exp_q.delete();
         return;
      end
      if (!m_inframe) begin
         if (s) begin
            m_inframe = 1'b1;
            m_idx     = 0;
            m_pay     = '0;
         end
      end else begin
         if (m_idx < int'(W)) m_pay[m_idx] = s;
         m_idx++;
         if (m_idx == int'(W) + 1) begin
            done      = 1'b1;
            err       = ((($countones(m_pay) + int'(s)) % 2) != 0);
            m_inframe = 1'b0;
         end
      end
      if (done) begin
         if (!m_valid || r) begin
            m_valid = 1'b1;
            exp_q.push_back('{data: m_pay, err: err});
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_valid && r) begin
         m_valid = 1'b0;
      end
   endtask

   // One clock: drive inputs, take the edge, update the model, settle.
   task automatic step(input bit s, input bit r, input bit rs = 1'b0,
                       input bit s1 = 1'b0, input bit r1 = 1'b0);
      bus0.serial_in = s;
      bus0.out_ready = r;
      bus1.serial_in = s1;
      bus1.out_ready = r1;
      rst            = rs;
      @(posedge clk);
      model_edge(rs, s, r);
      #1;
   endtask

   task automatic send0(input logic [W-1:0] data, input bit par, input bit r_last);
      step(1'b1, 1'b0);
      for (int i = 0; i < int'(W); i++) step(data[i], 1'b0);
      step(par, r_last);
   endtask

   // Monitor: flag checks every cycle, word pops on each consumer handshake.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("out_valid", 32'(bus0.out_valid), 32'(m_valid));
         chk("overrun", 32'(bus0.overrun), 32'(m_ovr));
         chk("busy", 32'(bus0.busy), 32'(m_inframe));
         if (bus0.out_valid && bus0.out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL word_pop: got word %0h with no word expected at %0t",
                        bus0.parallel_out, $time);
            end else begin
               e = exp_q.pop_front();
               chk("word_data", 32'(bus0.parallel_out), 32'(e.data));
               chk("word_perr", 32'(bus0.parity_err), 32'(e.err));
            end
         end
      end
   end

   initial begin
      bit s;
      bit r;
      bit rs;
      rst            = 1'b1;
      bus0.serial_in = 1'b0;
      bus0.out_ready = 1'b0;
      bus1.serial_in = 1'b0;
      bus1.out_ready = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      mon_en = 1'b1;
      step(1'b0, 1'b0, 1'b1);

      // Reset state on both instances.
      chk("rst_parallel0", 32'(bus0.parallel_out), 32'h0);
      chk("rst_perr0", 32'(bus0.parity_err), 32'h0);
      chk("rst_valid1", 32'(bus1.out_valid), 32'h0);
      chk("rst_busy1", 32'(bus1.busy), 32'h0);

      // No-parity frame on dut1: start, then 0,1,0,1 LSB-first.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("np_valid_early", 32'(bus1.out_valid), 32'h0);
      chk("np_busy_mid", 32'(bus1.busy), 32'h1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("np_valid", 32'(bus1.out_valid), 32'h1);
      chk("np_data", 32'(bus1.parallel_out), 32'(4'b1010));
      chk("np_perr", 32'(bus1.parity_err), 32'h0);
      chk("np_busy_done", 32'(bus1.busy), 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("np_consumed", 32'(bus1.out_valid), 32'h0);
      chk("np_hold", 32'(bus1.parallel_out), 32'(4'b1010));

      // Idle line after reset stays quiet.
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
      chk("idle_busy", 32'(bus0.busy), 32'h0);
      chk("idle_valid", 32'(bus0.out_valid), 32'h0);

      // Good parity frame 1101, consumer stalled.
      send0(4'b1101, 1'b1, 1'b0);
      chk("f1_data", 32'(bus0.parallel_out), 32'(4'b1101));
      chk("f1_valid", 32'(bus0.out_valid), 32'h1);
      chk("f1_perr", 32'(bus0.parity_err), 32'h0);
      step(1'b0, 1'b1);

      // Same payload with bad parity.
      send0(4'b1101, 1'b0, 1'b0);
      chk("f2_data", 32'(bus0.parallel_out), 32'(4'b1101));
      chk("f2_perr", 32'(bus0.parity_err), 32'h1);
      step(1'b0, 1'b1);

      // Back-to-back, second frame dropped while first is unconsumed.
      send0(4'b1101, 1'b1, 1'b0);
      send0(4'b0010, 1'b1, 1'b0);
      chk("ovr_data", 32'(bus0.parallel_out), 32'(4'b1101));
      chk("ovr_flag", 32'(bus0.overrun), 32'h1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);

      // Back-to-back, consumer ready on the completion edge.
      send0(4'b1101, 1'b1, 1'b0);
      send0(4'b0010, 1'b1, 1'b1);
      chk("b2b_data", 32'(bus0.parallel_out), 32'(4'b0010));
      chk("b2b_ovr", 32'(bus0.overrun), 32'h0);
      chk("b2b_valid", 32'(bus0.out_valid), 32'h1);
      step(1'b0, 1'b1);

      // Reset mid-frame after three payload bits, then a clean frame.
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk("abort_valid", 32'(bus0.out_valid), 32'h0);
      chk("abort_busy", 32'(bus0.busy), 32'h0);
      send0(4'b0110, 1'b0, 1'b0);
      chk("abort_data", 32'(bus0.parallel_out), 32'(4'b0110));
      chk("abort_perr", 32'(bus0.parity_err), 32'h0);
      step(1'b0, 1'b1);

      // Random line activity, stalls and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         s  = ($urandom_range(0, 99) < 55);
         r  = ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 299) == 0);
         step(s, r, rs);
      end

      // Drain: idle line, consumer always ready.
      for (int i = 0; i < int'(W) + 4; i++) step(1'b0, 1'b1);
      chk("drain_queue", 32'(exp_q.size()), 32'h0);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
